// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_CH    = 4;
  localparam int SLOT_W    = 2;
  localparam int LAST_SLOT = NUM_CH - 1;

endpackage

// File: rtl/demux_1_4_n_bit_tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer: clear, load-to-1 and advance (wrapping),
// with a flag marking the final slot of a frame.
module tdm_slot_counter
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_one,
  input  logic              advance,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  // Slot register; clear wins over load, load wins over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= {SLOT_W{1'b0}};
    end else if (clear) begin
      slot <= {SLOT_W{1'b0}};
    end else if (load_one) begin
      slot <= SLOT_W'(1);
    end else if (advance) begin
      slot <= slot + SLOT_W'(1);
    end else begin
      slot <= slot;
    end
  end

  // Final-slot flag derived from the registered count.
  always_comb begin
    last_slot = (slot == SLOT_W'(LAST_SLOT));
  end

endmodule

// File: rtl/demux_1_4_n_bit_tdm.sv
// Registered 1-to-4 N-bit TDM demultiplexer with atomic frame presentation.
// Framing checks and early-sof resync are enabled by macro DEMUX_SYNC_CHECK_EN.
module demux_1_4_n_bit_tdm
  import demux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sof,
  input  logic [N-1:0] din,
  output logic [N-1:0] o0,
  output logic [N-1:0] o1,
  output logic [N-1:0] o2,
  output logic [N-1:0] o3,
  output logic         s0,
  output logic         s1,
  output logic         frame_valid,
  output logic         err
);

  state_t             state_r;
  state_t             next_state_s;
  logic [N-1:0]       stage0_r;
  logic [N-1:0]       stage1_r;
  logic [N-1:0]       stage2_r;
  logic [SLOT_W-1:0]  slot_s;
  logic               last_slot_s;
  logic               cnt_clear_s;
  logic               cnt_load_s;
  logic               cnt_adv_s;
  logic               cap0_s;
  logic               capk_s;
  logic               emit_s;
  logic               err_s;

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear_s),
    .load_one  (cnt_load_s),
    .advance   (cnt_adv_s),
    .slot      (slot_s),
    .last_slot (last_slot_s)
  );

  // Decode the action for the current word from state, slot and sof.
  always_comb begin
    next_state_s = state_r;
    cnt_clear_s  = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_adv_s    = 1'b0;
    cap0_s       = 1'b0;
    capk_s       = 1'b0;
    emit_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && sof) begin
          cap0_s       = 1'b1;
          cnt_load_s   = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (in_valid) begin
`ifdef DEMUX_SYNC_CHECK_EN
          if (slot_s == SLOT_W'(0)) begin
            if (sof) begin
              cap0_s     = 1'b1;
              cnt_load_s = 1'b1;
            end else begin
              err_s        = 1'b1;
              cnt_clear_s  = 1'b1;
              next_state_s = IDLE;
            end
          end else if (sof) begin
            // Early sof: drop the partial frame and restart on this word.
            err_s      = 1'b1;
            cap0_s     = 1'b1;
            cnt_load_s = 1'b1;
          end else if (last_slot_s) begin
            emit_s    = 1'b1;
            cnt_adv_s = 1'b1;
          end else begin
            capk_s    = 1'b1;
            cnt_adv_s = 1'b1;
          end
`else
          if (last_slot_s) begin
            emit_s    = 1'b1;
            cnt_adv_s = 1'b1;
          end else begin
            capk_s    = 1'b1;
            cnt_adv_s = 1'b1;
          end
`endif
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        cnt_clear_s  = 1'b1;
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, staging registers, output registers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      stage0_r    <= {N{1'b0}};
      stage1_r    <= {N{1'b0}};
      stage2_r    <= {N{1'b0}};
      o0          <= {N{1'b0}};
      o1          <= {N{1'b0}};
      o2          <= {N{1'b0}};
      o3          <= {N{1'b0}};
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      frame_valid <= emit_s;
      err         <= err_s;
      if (cap0_s) begin
        stage0_r <= din;
      end else if (capk_s) begin
        case (slot_s)
          2'd0:    stage0_r <= din;
          2'd1:    stage1_r <= din;
          2'd2:    stage2_r <= din;
          default: stage0_r <= stage0_r;
        endcase
      end else begin
        stage0_r <= stage0_r;
      end
      // Slot 3 word goes straight to o3 so all four channels change together.
      if (emit_s) begin
        o0 <= stage0_r;
        o1 <= stage1_r;
        o2 <= stage2_r;
        o3 <= din;
      end else begin
        o0 <= o0;
      end
    end
  end

  assign s0 = slot_s[0];
  assign s1 = slot_s[1];

endmodule

// File: doc/demux_1_4_n_bit_tdm.md
# demux_1_4_n_bit_tdm

Registered 1-to-4 N-bit time-division demultiplexer: the receive-side counterpart of the 4x1 N-bit MUX. It accepts a serial stream of N-bit words, one per slot, in slot order 0,1,2,3 with slot 0 flagged by `sof`. It distributes the words to four output channels, presents all four atomically once a full frame is captured, and reports framing errors.

## Interface
Parameters:
- `N`, default 4: data width per channel.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `in_valid`  input  1  `din`/`sof` carry a word this cycle.
- `sof`  input  1  start of frame; qualifies the word as slot 0; ignored unless `in_valid`.
- `din`  input  N  serial data word.
- `o0`, `o1`, `o2`, `o3`  output  N each  channel outputs, registered; slots 0 to 3 of the last complete frame.
- `s0`, `s1`  output  1 each  slot index expected next, `{s1,s0}`, same encoding as the MUX select.
- `frame_valid`  output  1  one-cycle pulse; `o0`–`o3` just updated.
- `err`  output  1  one-cycle pulse on a framing violation.

## Operation
- Reset values: `o0`–`o3` = 0, `{s1,s0}` = 00, `frame_valid` = 0, `err` = 0, state IDLE, staging registers = 0.
- FSM states are IDLE and RUN. Slot counter is 2 bits.
- **IDLE**
  - `in_valid & sof`: store `din` in stage[0], slot←1, go to RUN.
  - `in_valid & !sof`: discard the word; no `err`.
- **RUN**, on an accepted word at slot k:
  - k=0 with `sof`: stage[0]←`din`, slot←1.
  - k=0 without `sof`: `err` pulse, word discarded, go to IDLE, slot←0.
  - k=1..3 without `sof`: stage[k]←`din`, slot←k+1 (wraps 3→0).
  - k=1..3 with `sof` (early sof): `err` pulse, partial frame discarded, word captured as stage[0], slot←1, stay in RUN (resync).
  - k=3 accepted: `o0`–`o2`←stage[0..2] and `o3`←`din`, all on the same edge; `frame_valid` pulses; slot←0.
- `in_valid` low: no state change. Gaps of any length between words are allowed.
- `o0`–`o3` hold their value between frames. They never show a partial frame.
- `rst` asserted mid-frame: the partial frame is lost, all outputs return to reset values on the next edge, and `frame_valid` is not pulsed.
- `err` and `frame_valid` can never be asserted in the same cycle.

## Timing
- Latency: the slot-3 word is accepted at edge E. `o0`–`o3` update and `frame_valid`=1 are visible after E, during cycle E+1 only.
- `{s1,s0}` update on the edge that accepts a word.
- `err` is registered. It is high during the single cycle following the offending word.
- Back-to-back frames at full rate (4 consecutive `in_valid` cycles per frame) are supported with no bubble.

## Configuration
- Macro `DEMUX_SYNC_CHECK_EN`.
- Defined: behaviour as above, including error detection and early-sof resync.
- Undefined:
  - `err` is tied to 0.
  - `sof` is honoured only in IDLE.
  - In RUN the slot counter free-runs on `in_valid` and `sof` is ignored.
  - Slot 0 in RUN captures without checking `sof`.

## Structure
- Package `demux_pkg`:
  - state enum `{IDLE, RUN}`
  - `NUM_CH` = 4
  - `SLOT_W` = 2
- Sub-module `tdm_slot_counter`:
  - 2-bit counter with load-to-1 and clear.
  - Drives `{s1,s0}` and a `last_slot` flag.
- Top level holds the FSM, the staging registers and the output registers.

## Test plan
All scenarios use N=4.
- Reset, then idle 5 cycles -> all outputs 0, `{s1,s0}`=00, no pulses.
- Frame 0010 (sof), 0110, 1111, 1000 on 4 consecutive cycles -> next cycle `o0`=0010, `o1`=0110, `o2`=1111, `o3`=1000, `frame_valid`=1 for exactly 1 cycle.
- Same frame with 3-cycle `in_valid` gaps between words, then two back-to-back frames -> identical outputs; one `frame_valid` per frame; no bubble between the back-to-back frames.
- Early sof: 0010 (sof), 0110, then 1111 with sof, 0001, 0011, 0111 -> `err` pulse one cycle after 1111; the frame then completes with `o0`=1111, `o1`=0001, `o2`=0011, `o3`=0111.
- Missing sof after a frame, or `rst` asserted at slot 2 -> missing sof: `err` pulse, return to IDLE, outputs hold the prior frame. Reset at slot 2: outputs cleared, no `frame_valid`.
- With `DEMUX_SYNC_CHECK_EN` undefined, repeat the early-sof stimulus -> `err` stays 0 and words land in slots by count.
